// File: rtl/jk_d_ff_pkg.sv
// Shared types and the JK next-state rule for the jk_d_ff bank.
// Optional qn output is controlled by the JK_D_QN_EN macro.
package jk_d_pkg;

    // JK operating mode, encoded as {j,k}
    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_mode_t;

    function automatic logic jk_next(input jk_mode_t mode, input logic q);
        logic nxt;
        nxt = q;
        case (mode)
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TGL:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_d_ff_if.sv
// J/K inputs and q (plus qn when JK_D_QN_EN is defined) bundled for the jk_d_ff bank.
interface jk_d_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
`ifdef JK_D_QN_EN
    logic [WIDTH-1:0] qn;

    modport master (output j, output k, input q, input qn);
    modport slave  (input j, input k, output q, output qn);
`else
    modport master (output j, output k, input q);
    modport slave  (input j, input k, output q);
`endif
endinterface

// File: rtl/jk_d_ff_dff.sv
// WIDTH-wide D register with synchronous active-high reset to RESET_VAL.
// When JK_D_QN_EN is defined, a registered complement qn is kept alongside q.
module jk_d_dff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             c,
    input  logic             r,
    input  logic [WIDTH-1:0] d,
`ifdef JK_D_QN_EN
    output logic [WIDTH-1:0] qn,
`endif
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge c) begin
        if (r) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

`ifdef JK_D_QN_EN
    // Separate flop rather than an inverter so qn shares q's timing exactly
    always_ff @(posedge c) begin
        if (r) begin
            qn <= ~RESET_VAL;
        end else begin
            qn <= ~d;
        end
    end
`endif

endmodule

// File: rtl/jk_d_ff.sv
// JK flip-flop bank: per-bit J/K-to-D conversion feeding one jk_d_dff register.
// Define JK_D_QN_EN to add the registered complement output qn.
module jk_d_ff
    import jk_d_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         c,
    input  logic         r,
    jk_d_ff_if.slave     bus
);

    logic [WIDTH-1:0] d;

    always_comb begin
        d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            d[i] = jk_next(jk_mode_t'({bus.j[i], bus.k[i]}), bus.q[i]);
        end
    end

    jk_d_dff #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_reg (
        .c  (c),
        .r  (r),
        .d  (d),
`ifdef JK_D_QN_EN
        .qn (bus.qn),
`endif
        .q  (bus.q)
    );

endmodule

// File: tb/tb_jk_d_ff.sv
// Scoreboard bench for jk_d_ff: a 1-bit bank and a 4-bit bank (RESET_VAL=1010) run side by side.
// Checks qn as well when JK_D_QN_EN is defined.
module tb_jk_d_ff;

    logic c;
    logic r1;
    logic r4;

    jk_d_ff_if #(.WIDTH(1)) bus1 ();
    jk_d_ff_if #(.WIDTH(4)) bus4 ();

    jk_d_ff #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .c   (c),
        .r   (r1),
        .bus (bus1)
    );

    jk_d_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
        .c   (c),
        .r   (r4),
        .bus (bus4)
    );

    initial c = 1'b0;
    always #2 c = ~c;

    typedef struct {
        string      tag;
        logic [3:0] q1;
        logic [3:0] q4;
    } exp_t;

    exp_t sb[$];
    int   check_count = 0;
    int   pass_count  = 0;
    logic [3:0] m1 = '0;
    logic [3:0] m4 = '0;
    bit   stim_done = 0;

    task automatic check_output(input string name, input logic [3:0] act, input logic [3:0] exp);
        check_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Behavioural model straight from the JK truth table, bit by bit
    function automatic logic [3:0] ref_next(input int width, input logic rr,
                                            input logic [3:0] jj, input logic [3:0] kk,
                                            input logic [3:0] qq, input logic [3:0] rv);
        logic [3:0] n;
        if (rr) return rv;
        n = qq;
        for (int b = 0; b < width; b++) begin
            if (jj[b] && kk[b])      n[b] = ~qq[b];
            else if (jj[b])          n[b] = 1'b1;
            else if (kk[b])          n[b] = 1'b0;
        end
        return n;
    endfunction

    task automatic apply_stimulus(input string tag,
                                  input logic rr1, input logic jj1, input logic kk1,
                                  input logic rr4, input logic [3:0] jj4, input logic [3:0] kk4);
        exp_t e;
        @(negedge c);
        r1     = rr1;
        bus1.j = jj1;
        bus1.k = kk1;
        r4     = rr4;
        bus4.j = jj4;
        bus4.k = kk4;
        m1 = ref_next(1, rr1, {3'b000, jj1}, {3'b000, kk1}, m1, 4'b0000) & 4'b0001;
        m4 = ref_next(4, rr4, jj4, kk4, m4, 4'b1010);
        e.tag = tag;
        e.q1  = m1;
        e.q4  = m4;
        sb.push_back(e);
    endtask

    // Monitor: q is presented every cycle, so each edge retires one expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge c);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output({e.tag, "_q1"}, {3'b000, bus1.q}, e.q1);
                check_output({e.tag, "_q4"}, bus4.q, e.q4);
`ifdef JK_D_QN_EN
                check_output({e.tag, "_qn1"}, {3'b000, bus1.qn}, {3'b000, ~e.q1[0]});
                check_output({e.tag, "_qn4"}, bus4.qn, ~e.q4);
`endif
            end
        end
    end

    initial begin
        #90000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        r1 = 1'b1; bus1.j = 1'b0; bus1.k = 1'b0;
        r4 = 1'b1; bus4.j = 4'b0000; bus4.k = 4'b0000;

        // Reset, with X on the 4-bit bank's J/K in the second cycle
        apply_stimulus("reset", 1, 0, 0, 1, 4'b0000, 4'b0000);
        apply_stimulus("reset_x", 1, 0, 0, 1, 4'bxxxx, 4'bxxxx);

        // 1-bit set; 4-bit per-bit HOLD/SET/CLR/TGL from MSB
        apply_stimulus("set", 0, 1, 0, 0, 4'b0101, 4'b0011);
        apply_stimulus("set_stay", 0, 1, 0, 0, 4'b0000, 4'b0000);
        apply_stimulus("set_stay", 0, 1, 0, 0, 4'b0000, 4'b0000);

        repeat (3) apply_stimulus("toggle", 0, 1, 1, 0, 4'b1111, 4'b1111);
        repeat (3) apply_stimulus("hold", 0, 0, 0, 0, 4'b0000, 4'b0000);

        apply_stimulus("preset", 0, 1, 0, 0, 4'b0000, 4'b1111);
        apply_stimulus("mid_reset", 1, 1, 0, 0, 4'b1111, 4'b0000);
        #1;
        check_output("mid_reset_hold", {3'b000, bus1.q}, 4'b0001);
        apply_stimulus("reset_beats_j", 1, 1, 0, 1, 4'b1111, 4'b0000);
        apply_stimulus("reset_clr", 1, 0, 1, 1, 4'b0000, 4'b1111);

        for (int n = 0; n < 200; n++) begin
            apply_stimulus("rand",
                           ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                           ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom));
        end

        @(negedge c);
        @(negedge c);
        check_output("sb_drained", 4'(sb.size()), 4'd0);
        stim_done = 1;
        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
